// File: rtl/mem_handshake_unit_pkg.sv
// Shared encodings for the handshake memory: access sizes, read/write, FSM states.
package mem_handshake_unit_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_ILLEG = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage with a 4-lane write and a combinational 4-byte read at one base address.
// Lane 0 sits at the base address and maps to bits [31:24] (big-endian).
module mem_byte_array #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic [3:0]        i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] w_idx [4];

   // Lanes past the top of the array wrap; only unaligned byte/half reads touch them and discard them.
   always_comb begin
      for (int l = 0; l < 4; l++) begin
         w_idx[l] = i_addr + ADDR_W'(l);
      end
   end

   assign o_rdata = {r_mem[w_idx[0]], r_mem[w_idx[1]], r_mem[w_idx[2]], r_mem[w_idx[3]]};

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (i_we[3-l]) begin
            r_mem[w_idx[l]] <= i_wdata[31-8*l -: 8];
         end
      end
   end

endmodule

// File: rtl/mem_handshake_unit.sv
// Byte-addressed big-endian memory behind a four-phase MOV/MOC handshake,
// with configurable latency, sized accesses, read extension and alignment errors.
//
//   state | meaning
//   IDLE  | waiting for mov; request fields captured on acceptance
//   BUSY  | latency countdown; mov low aborts without side effects
//   DONE  | moc/err/data_out held until mov drops
module mem_handshake_unit
   import mem_handshake_unit_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mov,
   input  logic              rw,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              moc,
   output logic              err,
   output logic              busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_fire;

   logic              r_rw;
   logic [1:0]        r_size;
   logic              r_sext;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_cnt;

   logic              r_moc;
   logic              r_err;
   logic [31:0]       r_data_out;

   logic              w_bad;
   logic [3:0]        w_lane_mask;
   logic [31:0]       w_wr_word;
   logic [3:0]        w_we;
   logic [31:0]       w_rd_word;
   logic [31:0]       w_rd_ext;

   mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (r_addr),
      .i_wdata (w_wr_word),
      .o_rdata (w_rd_word)
   );

   always_comb begin
      w_bad = 1'b0;
      case (r_size)
         SZ_BYTE: w_bad = 1'b0;
         SZ_HALF: w_bad = r_addr[0];
         SZ_WORD: w_bad = (r_addr[1:0] != 2'b00);
         default: w_bad = 1'b1;
      endcase
   end

   always_comb begin
      w_lane_mask = 4'b0000;
      w_wr_word   = r_wdata;
      w_rd_ext    = w_rd_word;
      case (r_size)
         SZ_BYTE: begin
            w_lane_mask = 4'b1000;
            w_wr_word   = {r_wdata[7:0], 24'h0};
            w_rd_ext    = {{24{r_sext & w_rd_word[31]}}, w_rd_word[31:24]};
         end
         SZ_HALF: begin
            w_lane_mask = 4'b1100;
            w_wr_word   = {r_wdata[15:0], 16'h0};
            w_rd_ext    = {{16{r_sext & w_rd_word[31]}}, w_rd_word[31:16]};
         end
         SZ_WORD: begin
            w_lane_mask = 4'b1111;
         end
         default: begin
            w_lane_mask = 4'b0000;
         end
      endcase
   end

   assign w_we = (w_fire && !w_bad && (r_rw == RW_WRITE)) ? w_lane_mask : 4'b0000;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fire      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mov) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!mov) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_fire      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!mov) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rw       <= RW_READ;
         r_size     <= SZ_BYTE;
         r_sext     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_cnt      <= 4'd0;
         r_moc      <= 1'b0;
         r_err      <= 1'b0;
         r_data_out <= 32'h0;
      end else begin
         if (w_accept) begin
            r_rw    <= rw;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_addr  <= addr;
            r_wdata <= data_in;
            r_cnt   <= 4'(LATENCY - 1);
         end else if ((r_state == ST_BUSY) && mov && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_fire) begin
            r_moc <= 1'b1;
            r_err <= w_bad;
            if (w_bad) begin
               r_data_out <= 32'h0;
            end else if (r_rw == RW_READ) begin
               r_data_out <= w_rd_ext;
            end
         end else if ((r_state == ST_DONE) && !mov) begin
            r_moc <= 1'b0;
            r_err <= 1'b0;
         end
      end
   end

   assign moc      = r_moc;
   assign err      = r_err;
   assign data_out = r_data_out;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Directed bench: three instances share one request bus; each test targets one instance.
module tb_mem_handshake_unit;

   logic        clk;
   logic        reset;
   logic        mov;
   logic        rw;
   logic [1:0]  size;
   logic        sign_ext;
   logic [9:0]  addr;
   logic [31:0] data_in;

   logic [31:0] dout_a, dout_b, dout_c;
   logic        moc_a, moc_b, moc_c;
   logic        err_a, err_b, err_c;
   logic        busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;

   mem_handshake_unit #(.ADDR_W(9), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
      .addr(addr[8:0]), .data_in(data_in), .data_out(dout_a), .moc(moc_a), .err(err_a), .busy(busy_a)
   );

   mem_handshake_unit #(.ADDR_W(9), .LATENCY(3)) dut_b (
      .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
      .addr(addr[8:0]), .data_in(data_in), .data_out(dout_b), .moc(moc_b), .err(err_b), .busy(busy_b)
   );

   mem_handshake_unit #(.ADDR_W(10), .LATENCY(1)) dut_c (
      .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
      .addr(addr), .data_in(data_in), .data_out(dout_c), .moc(moc_c), .err(err_c), .busy(busy_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic sel_moc(input int s);
      case (s)
         0: return moc_a;
         1: return moc_b;
         default: return moc_c;
      endcase
   endfunction

   function automatic logic sel_busy(input int s);
      case (s)
         0: return busy_a;
         1: return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic sel_err(input int s);
      case (s)
         0: return err_a;
         1: return err_b;
         default: return err_c;
      endcase
   endfunction

   function automatic logic [31:0] sel_dout(input int s);
      case (s)
         0: return dout_a;
         1: return dout_b;
         default: return dout_c;
      endcase
   endfunction

   // One full handshake on the shared bus, judged against instance sel.
   // Request inputs are scrambled after acceptance; hold keeps mov high extra cycles in DONE.
   task automatic xact(input logic t_rw, input logic [1:0] t_size, input logic t_sext,
                       input logic [9:0] t_addr, input logic [31:0] t_din, input int sel,
                       input int hold, output int lat, output logic [31:0] t_dout, output logic t_err);
      int  cyc;
      logic done;
      @(negedge clk);
      mov = 1'b1; rw = t_rw; size = t_size; sign_ext = t_sext; addr = t_addr; data_in = t_din;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            addr = ~addr; data_in = ~data_in; sign_ext = ~sign_ext;
         end
         if (sel_moc(sel)) done = 1'b1;
      end
      lat = cyc - 1;
      if (!done) begin
         checks++; errors++;
         $display("FAIL xact_timeout sel=%0d moc never rose within %0d cycles", sel, cyc);
         lat = -1;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (sel_moc(sel) !== 1'b1) begin
            errors++;
            $display("FAIL done_hold sel=%0d moc=%b expected 1", sel, sel_moc(sel));
         end
      end
      t_dout = sel_dout(sel);
      t_err  = sel_err(sel);
      mov = 1'b0;
      @(negedge clk);
      checks++;
      if (sel_moc(sel) !== 1'b0) begin
         errors++;
         $display("FAIL moc_drop sel=%0d moc=%b expected 0", sel, sel_moc(sel));
      end
      checks++;
      if (sel_busy(sel) !== 1'b0) begin
         errors++;
         $display("FAIL busy_drop sel=%0d busy=%b expected 0", sel, sel_busy(sel));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mov = 1'b0; rw = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = '0; data_in = '0;
      dut_a.u_array.r_mem[0] = 8'hDE;
      dut_a.u_array.r_mem[1] = 8'hAD;
      dut_a.u_array.r_mem[2] = 8'hBE;
      dut_a.u_array.r_mem[3] = 8'hEF;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (moc_a !== 1'b0) begin errors++; $display("FAIL reset_moc got=%b exp=0", moc_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      checks++; if (dout_a !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout_a); end
   endtask

   task automatic test_word_read();
      int lat; logic [31:0] d; logic e;
      xact(1'b1, 2'b10, 1'b0, 10'd0, 32'h0, 0, 1, lat, d, e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL word_read_latency got=%0d exp=2", lat); end
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_data got=%h exp=DEADBEEF", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_read_err got=%b exp=0", e); end
   endtask

   task automatic test_read_ext();
      int lat; logic [31:0] d; logic e;
      xact(1'b1, 2'b00, 1'b1, 10'd2, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'hFFFFFFBE) begin errors++; $display("FAIL byte_sext got=%h exp=FFFFFFBE", d); end
      xact(1'b1, 2'b00, 1'b0, 10'd2, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'h000000BE) begin errors++; $display("FAIL byte_zext got=%h exp=000000BE", d); end
      xact(1'b1, 2'b01, 1'b1, 10'd2, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_sext got=%h exp=FFFFBEEF", d); end
      xact(1'b1, 2'b01, 1'b0, 10'd0, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'h0000DEAD) begin errors++; $display("FAIL half_zext got=%h exp=0000DEAD", d); end
      xact(1'b1, 2'b00, 1'b1, 10'd3, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'hFFFFFFEF) begin errors++; $display("FAIL byte3_sext got=%h exp=FFFFFFEF", d); end
   endtask

   task automatic test_half_write();
      int lat; logic [31:0] d; logic e;
      dut_a.u_array.r_mem[4] = 8'h11;
      dut_a.u_array.r_mem[5] = 8'h22;
      dut_a.u_array.r_mem[6] = 8'h33;
      dut_a.u_array.r_mem[7] = 8'h44;
      xact(1'b0, 2'b01, 1'b0, 10'd6, 32'h12345678, 0, 0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL half_write_err got=%b exp=0", e); end
      xact(1'b1, 2'b10, 1'b0, 10'd4, 32'h0, 0, 0, lat, d, e);
      checks++; if (d !== 32'h11225678) begin errors++; $display("FAIL half_write_readback got=%h exp=11225678", d); end
      checks++; if (dut_a.u_array.r_mem[5] !== 8'h22) begin errors++; $display("FAIL half_write_mem5 got=%h exp=22", dut_a.u_array.r_mem[5]); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] d; logic e;
      dut_a.u_array.r_mem[5] = 8'hA0;
      dut_a.u_array.r_mem[6] = 8'hA1;
      dut_a.u_array.r_mem[7] = 8'hA2;
      dut_a.u_array.r_mem[8] = 8'hA3;
      xact(1'b0, 2'b10, 1'b0, 10'd5, 32'hFFFFFFFF, 0, 0, lat, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_word_err got=%b exp=1", e); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL misalign_word_dout got=%h exp=0", d); end
      checks++;
      if ({dut_a.u_array.r_mem[5], dut_a.u_array.r_mem[6], dut_a.u_array.r_mem[7], dut_a.u_array.r_mem[8]} !== 32'hA0A1A2A3) begin
         errors++;
         $display("FAIL misalign_word_mem got=%h%h%h%h exp=A0A1A2A3", dut_a.u_array.r_mem[5],
                  dut_a.u_array.r_mem[6], dut_a.u_array.r_mem[7], dut_a.u_array.r_mem[8]);
      end
      xact(1'b1, 2'b11, 1'b0, 10'd0, 32'h0, 0, 0, lat, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal_size_err got=%b exp=1", e); end
      xact(1'b1, 2'b01, 1'b0, 10'd3, 32'h0, 0, 0, lat, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_half_err got=%b exp=1", e); end
      xact(1'b1, 2'b10, 1'b0, 10'd0, 32'h0, 0, 0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL aligned_after_err got=%b exp=0", e); end
   endtask

   task automatic test_abort();
      for (int i = 8; i < 12; i++) dut_b.u_array.r_mem[i] = 8'h00;
      @(negedge clk);
      mov = 1'b1; rw = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 10'd8; data_in = 32'h55AA55AA;
      @(negedge clk);
      checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL abort_busy_high got=%b exp=1", busy_b); end
      mov = 1'b0;
      @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL abort_busy_low got=%b exp=0", busy_b); end
      repeat (4) @(negedge clk);
      checks++; if (moc_b !== 1'b0) begin errors++; $display("FAIL abort_moc got=%b exp=0", moc_b); end
      checks++;
      if ({dut_b.u_array.r_mem[8], dut_b.u_array.r_mem[9], dut_b.u_array.r_mem[10], dut_b.u_array.r_mem[11]} !== 32'h0) begin
         errors++;
         $display("FAIL abort_mem got=%h%h%h%h exp=00000000", dut_b.u_array.r_mem[8],
                  dut_b.u_array.r_mem[9], dut_b.u_array.r_mem[10], dut_b.u_array.r_mem[11]);
      end
   endtask

   task automatic test_reset_busy();
      for (int i = 12; i < 16; i++) dut_a.u_array.r_mem[i] = 8'h77;
      @(negedge clk);
      mov = 1'b1; rw = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 10'd12; data_in = 32'h01020304;
      @(negedge clk);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy_pre got=%b exp=1", busy_a); end
      #2 reset = 1'b1;
      #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy_busy got=%b exp=0", busy_a); end
      checks++; if (dout_a !== 32'h0) begin errors++; $display("FAIL rst_busy_dout got=%h exp=0", dout_a); end
      checks++; if ({moc_a, err_a} !== 2'b00) begin errors++; $display("FAIL rst_busy_mocerr got=%b exp=00", {moc_a, err_a}); end
      @(negedge clk);
      mov = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({dut_a.u_array.r_mem[12], dut_a.u_array.r_mem[15]} !== 16'h7777) begin
         errors++;
         $display("FAIL rst_busy_mem got=%h%h exp=7777", dut_a.u_array.r_mem[12], dut_a.u_array.r_mem[15]);
      end
   endtask

   task automatic test_sweep();
      int lat; logic [31:0] d; logic e;
      xact(1'b0, 2'b10, 1'b0, 10'd1020, 32'hCAFEF00D, 2, 0, lat, d, e);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sweep_wr_latency got=%0d exp=1", lat); end
      checks++; if (dut_c.u_array.r_mem[1023] !== 8'h0D) begin errors++; $display("FAIL sweep_mem1023 got=%h exp=0D", dut_c.u_array.r_mem[1023]); end
      xact(1'b1, 2'b10, 1'b0, 10'd1020, 32'h0, 2, 0, lat, d, e);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sweep_rd_latency got=%0d exp=1", lat); end
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL sweep_rd_data got=%h exp=CAFEF00D", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL sweep_rd_err got=%b exp=0", e); end
   endtask

   task automatic test_reset_done();
      @(negedge clk);
      mov = 1'b1; rw = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 10'd1020; data_in = 32'h0;
      repeat (2) @(negedge clk);
      checks++; if (moc_c !== 1'b1) begin errors++; $display("FAIL rst_done_pre got=%b exp=1", moc_c); end
      #2 reset = 1'b1;
      #1;
      checks++; if (moc_c !== 1'b0) begin errors++; $display("FAIL rst_done_moc got=%b exp=0", moc_c); end
      checks++; if (dout_c !== 32'h0) begin errors++; $display("FAIL rst_done_dout got=%h exp=0", dout_c); end
      @(negedge clk);
      mov = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_read_ext();
      test_half_write();
      test_errors();
      test_abort();
      test_reset_busy();
      test_sweep();
      test_reset_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_handshake_unit.md
Name: mem_handshake_unit

Overview:
- Parametrised, byte-addressed, big-endian data/instruction memory for the MIPS datapath. Successor to the fixed 512x8 RAM.
- Uses the same MOV/MOC four-phase handshake as the existing RAM.
- Adds configurable depth and latency, byte/halfword/word access with optional sign extension, alignment-error reporting, and abort on early MOV release.

Parameters:
- ADDR_W, 9, address width in bits; DEPTH = 2**ADDR_W bytes.
- LATENCY, 2, cycles from request acceptance to MOC rise; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mov  in  1  memory operation valid (request) from the control unit.
- rw  in  1  1 = read, 0 = write.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- sign_ext  in  1  reads only: 1 = sign-extend, 0 = zero-extend to 32 bits.
- addr  in  ADDR_W  byte address.
- data_in  in  32  write data, right-justified.
- data_out  out  32  read data, right-justified and extended.
- moc  out  1  memory operation complete.
- err  out  1  misaligned or illegal access; valid while moc = 1.
- busy  out  1  high in the BUSY and DONE states.

Behaviour:
- Reset (asynchronous): state = IDLE; moc = 0, err = 0, busy = 0, data_out = 0, latency counter = 0. The memory array is NOT cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If mov = 1 at a rising edge, capture rw, size, sign_ext, addr and data_in; load counter = LATENCY-1; go to BUSY.
  - Inputs changing after capture are ignored.
- BUSY:
  - If mov = 0 at an edge, abort: go to IDLE with no write and no moc.
  - Else if counter = 0: perform the access, set moc = 1, go to DONE.
  - Else decrement the counter.
- Timing: acceptance at edge k gives moc = 1 after edge k+LATENCY.
- DONE:
  - moc, err and data_out are held stable.
  - When mov = 0 at an edge, clear moc and err and go to IDLE. data_out holds its value.
  - A new request needs at least one cycle with mov = 0 (four-phase handshake).
- Access rules (byte lane order is big-endian, so Mem[a] is the MSB):
  - Byte: any address.
  - Half: addr[0] = 0; uses Mem[a], Mem[a+1].
  - Word: addr[1:0] = 00; uses Mem[a..a+3].
- Read: the data is extended per sign_ext. Sign extension copies bit 7 (byte) or bit 15 (halfword). Word reads ignore sign_ext.
- Write: only the size-selected bytes of Mem are updated, from data_in[7:0], data_in[15:0] or data_in[31:0]. The write happens at the same edge where moc rises.
- Error cases: misaligned address or size = 11 gives err = 1 with moc, no array write, and data_out = 0.
- Aligned accesses can never exceed DEPTH-1, so no wrap-around logic is needed.
- Reset during BUSY: no write occurs. Reset during DONE: moc falls immediately, asynchronously.
- Debug port for the bench: hierarchical access to the Mem array for preload, matching the existing RAM preload style.

Decomposition:
- Shared package/include file (mem_defs):
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - RW_READ and RW_WRITE constants.
  - FSM state encodings.
- Sub-module mem_byte_array: a pure storage array with a 4-lane byte write enable and a combinational 4-byte read at a base address.
- The FSM, alignment check, lane steering and extension logic stay in the top module.

Test Plan:
- Preload Mem[0..3] = 8'hDE, AD, BE, EF with LATENCY = 2. A word read at addr 0 gives moc high 2 cycles after acceptance, data_out = 32'hDEADBEEF, err = 0. Drop mov, then moc = 0 on the next edge.
- Byte read at addr 2 with sign_ext = 1 gives 32'hFFFFFFBE. With sign_ext = 0 it gives 32'h000000BE. Halfword read at addr 2 with sign_ext = 1 gives 32'hFFFFBEEF.
- Halfword write of data_in = 32'h12345678 at addr 6, then word read at addr 4, gives 32'hxxxx5678. Only Mem[6] = 8'h56 and Mem[7] = 8'h78 change; Mem[4] and Mem[5] keep their prior values.
- Word write at addr 5 (misaligned) gives moc = 1, err = 1, data_out = 0, and Mem[5..8] unchanged. A request with size = 11 also gives err = 1.
- Abort and reset: mov released 1 cycle after acceptance with LATENCY = 3 gives no moc and no write, and busy returns to 0. Reset asserted during BUSY of a write gives all outputs 0 immediately and the target bytes unchanged.
- Parameter sweep with ADDR_W = 10 and LATENCY = 1: word write then read at addr 1020 round-trips correctly, and moc rises exactly 1 cycle after acceptance.
